// File: rtl/simon_io_pkg.sv
// Shared types and packet geometry for the SIMON output packet interface.
// Packet byte positions are derived from the word width N.
package simon_io_pkg;

  localparam int unsigned SIMON_N = 16;
  localparam int unsigned BYTE_W  = 8;

  // Byte positions inside an output packet of (N/2 + 2) bytes.
  function automatic int unsigned pkt_bytes(input int unsigned n);
    return n / 2 + 2;
  endfunction

  function automatic int unsigned info_idx(input int unsigned n);
    return n / 2 + 1;
  endfunction

  function automatic int unsigned count_idx(input int unsigned n);
    return n / 2;
  endfunction

  function automatic int unsigned result_lsb(input int unsigned n);
    return n / 4;
  endfunction

  function automatic int unsigned result_bytes(input int unsigned n);
    return n / 4;
  endfunction

  typedef enum logic {
    C_IDLE,
    C_ACK
  } c_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_SEND,
    T_REL
  } t_state_t;

  // Buffered result for the default word width.
  typedef struct packed {
    logic [BYTE_W-1:0]    info;
    logic [2*SIMON_N-1:0] data;
  } entry_t;

endpackage

// File: rtl/simon_out_fifo.sv
// DEPTH-entry synchronous FIFO holding finished results between the core and host sides.
// Head entry is visible on dout whenever not empty; full/empty are registered flags.
module simon_out_fifo #(
  parameter int unsigned W     = 40,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         nR,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // Guard against pushing into a full or popping from an empty buffer.
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
    full_d  = (fill_d == (AW+1)'(DEPTH));
    empty_d = (fill_d == '0);
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/simon_data_out.sv
// Output packet interface of the SIMON datapath: core handshake -> result FIFO -> host packet.
// Define OUT_CHECKSUM_EN to place an XOR checksum of header and result bytes in pad byte 0.
module simon_data_out
  import simon_io_pkg::*;
#(
  parameter int unsigned N     = SIMON_N,
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 nR,
  input  logic                 newOUT,
  input  logic [1:0][N-1:0]    outDATA,
  input  logic [7:0]           infoOUT,
  output logic                 loadOUT,
  input  logic                 out_loadPKT,
  output logic                 out_newPKT,
  output logic                 out_donePKT,
  output logic [1+N/2:0][7:0]  out,
  output logic [7:0]           countOUT
);

  localparam int unsigned PKT_B   = pkt_bytes(N);
  localparam int unsigned INFO_IX = info_idx(N);
  localparam int unsigned CNT_IX  = count_idx(N);
  localparam int unsigned RES_LSB = result_lsb(N);
  localparam int unsigned RES_B   = result_bytes(N);

  typedef struct packed {
    logic [BYTE_W-1:0] info;
    logic [2*N-1:0]    data;
  } out_entry_t;

  typedef logic [PKT_B-1:0][BYTE_W-1:0] pkt_t;

  c_state_t   c_state_q, c_state_d;
  t_state_t   t_state_q, t_state_d;
  logic       load_out_q, load_out_d;
  logic       new_pkt_q, new_pkt_d;
  logic       done_pkt_q, done_pkt_d;
  pkt_t       pkt_q, pkt_d;
  pkt_t       pkt_asm;
  logic [7:0] cnt_q, cnt_d;

  logic       fifo_push, fifo_pop;
  logic       fifo_full, fifo_empty;
  out_entry_t wr_entry, head;

  assign wr_entry = {infoOUT, outDATA};

  simon_out_fifo #(
    .W     ($bits(out_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nR    (nR),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef OUT_CHECKSUM_EN
  // Running XOR over info, count and each result byte of the head entry.
  logic [RES_B:0][BYTE_W-1:0] csum_chain;

  assign csum_chain[0] = head.info ^ cnt_q;
  for (genvar gi = 0; gi < RES_B; gi++) begin : g_csum
    assign csum_chain[gi+1] = csum_chain[gi] ^ head.data[BYTE_W*gi +: BYTE_W];
  end
`endif

  always_comb begin
    pkt_asm                   = '0;
    pkt_asm[INFO_IX]          = head.info;
    pkt_asm[CNT_IX]           = cnt_q;
    pkt_asm[CNT_IX-1:RES_LSB] = head.data;
`ifdef OUT_CHECKSUM_EN
    pkt_asm[0]                = csum_chain[RES_B];
`endif
  end

  // Core side: one FIFO push per newOUT/loadOUT 4-phase handshake.
  always_comb begin
    c_state_d  = c_state_q;
    load_out_d = load_out_q;
    fifo_push  = 1'b0;
    case (c_state_q)
      C_IDLE: begin
        if (newOUT && !fifo_full) begin
          fifo_push  = 1'b1;
          load_out_d = 1'b1;
          c_state_d  = C_ACK;
        end
      end
      C_ACK: begin
        if (!newOUT) begin
          load_out_d = 1'b0;
          c_state_d  = C_IDLE;
        end
      end
      default: c_state_d = C_IDLE;
    endcase
  end

  // Host side: packet register is loaded only on pop and held through the handshake.
  always_comb begin
    t_state_d  = t_state_q;
    new_pkt_d  = new_pkt_q;
    done_pkt_d = 1'b0;
    pkt_d      = pkt_q;
    cnt_d      = cnt_q;
    fifo_pop   = 1'b0;
    case (t_state_q)
      T_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          pkt_d     = pkt_asm;
          new_pkt_d = 1'b1;
          t_state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (out_loadPKT) begin
          new_pkt_d = 1'b0;
          t_state_d = T_REL;
        end
      end
      T_REL: begin
        if (!out_loadPKT) begin
          done_pkt_d = 1'b1;
          cnt_d      = cnt_q + 8'd1;
          t_state_d  = T_IDLE;
        end
      end
      default: t_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      c_state_q  <= C_IDLE;
      t_state_q  <= T_IDLE;
      load_out_q <= 1'b0;
      new_pkt_q  <= 1'b0;
      done_pkt_q <= 1'b0;
      pkt_q      <= '0;
      cnt_q      <= '0;
    end else begin
      c_state_q  <= c_state_d;
      t_state_q  <= t_state_d;
      load_out_q <= load_out_d;
      new_pkt_q  <= new_pkt_d;
      done_pkt_q <= done_pkt_d;
      pkt_q      <= pkt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign loadOUT     = load_out_q;
  assign out_newPKT  = new_pkt_q;
  assign out_donePKT = done_pkt_q;
  assign out         = pkt_q;
  assign countOUT    = cnt_q;

endmodule

// File: tb/tb_simon_data_out.sv
// Self-checking bench for simon_data_out (N=16): vector table plus a packet scoreboard
// fed at stimulus time and drained by a host-side responder process.
module tb_simon_data_out;

  logic            clk = 1'b0;
  logic            nR = 1'b0;
  logic            newOUT = 1'b0;
  logic [1:0][15:0] outDATA = '0;
  logic [7:0]      infoOUT = '0;
  logic            loadOUT;
  logic            out_loadPKT;
  logic            host_load = 1'b0;
  logic            poke_load = 1'b0;
  logic            out_newPKT;
  logic            out_donePKT;
  logic [9:0][7:0] out;
  logic [7:0]      countOUT;

  assign out_loadPKT = host_load | poke_load;

  always #50 clk = ~clk;

  simon_data_out #(.N(16), .DEPTH(2)) dut (
    .clk         (clk),
    .nR          (nR),
    .newOUT      (newOUT),
    .outDATA     (outDATA),
    .infoOUT     (infoOUT),
    .loadOUT     (loadOUT),
    .out_loadPKT (out_loadPKT),
    .out_newPKT  (out_newPKT),
    .out_donePKT (out_donePKT),
    .out         (out),
    .countOUT    (countOUT)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [79:0] exp_q[$];
  logic [7:0]  pred_cnt = 8'd0;   // header count of the next pushed result
  logic [7:0]  model_cnt = 8'd0;  // completed packets seen by the host
  bit          host_en = 1'b0;
  bit          host_busy = 1'b0;
  int          host_delay = 0;

  typedef struct {
    logic [7:0]  info;
    logic [31:0] data;
    logic [79:0] exp_pkt;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  function automatic logic [79:0] add_pad(input logic [79:0] p);
    logic [79:0] r;
    r = p;
`ifdef OUT_CHECKSUM_EN
    r[7:0] = p[79:72] ^ p[71:64] ^ p[63:56] ^ p[55:48] ^ p[47:40] ^ p[39:32];
`endif
    return r;
  endfunction

  task automatic wait_load(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (loadOUT) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_result();
    newOUT = 1'b0;
    for (int i = 0; i < 10 && loadOUT; i++) @(negedge clk);
    if (loadOUT) fail("load_release");
  endtask

  task automatic drive(input logic [7:0] info, input logic [31:0] data, input logic [79:0] expect_pkt);
    infoOUT = info;
    outDATA = data;
    newOUT  = 1'b1;
    exp_q.push_back(add_pad(expect_pkt));
    pred_cnt = pred_cnt + 8'd1;
  endtask

  task automatic send(input logic [7:0] info, input logic [31:0] data, input string name);
    bit ok;
    drive(info, data, {info, pred_cnt, data, 32'h0});
    wait_load(40, ok);
    check(name, {79'd0, ok}, 80'd1);
    release_result();
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (exp_q.size() != 0 || host_busy); i++) @(negedge clk);
    if (exp_q.size() != 0 || host_busy) fail("drain_timeout");
  endtask

  // Host responder: compares each offered packet to the scoreboard, then runs the 4-phase.
  initial begin
    logic [79:0] e;
    forever begin
      @(negedge clk);
      if (!nR) model_cnt = 8'd0;
      if (host_en && nR && out_newPKT && !out_loadPKT) begin
        host_busy = 1'b1;
        if (exp_q.size() == 0) begin
          fail("sb_unexpected_pkt");
        end else begin
          e = exp_q.pop_front();
          check("sb_pkt", out, e);
          $display("pkt count=%h info=%h data=%h", out[8], out[9], out[7:4]);
        end
        repeat (host_delay) @(negedge clk);
        host_load = 1'b1;
        for (int i = 0; i < 20 && out_newPKT; i++) @(negedge clk);
        if (out_newPKT) fail("sb_newpkt_drop");
        host_load = 1'b0;
        @(negedge clk);
        check("sb_done", {79'd0, out_donePKT}, 80'd1);
        model_cnt = model_cnt + 8'd1;
        check("sb_count", {72'd0, countOUT}, {72'd0, model_cnt});
        @(negedge clk);
        check("sb_done_1cyc", {79'd0, out_donePKT}, 80'd0);
        host_busy = 1'b0;
      end
    end
  end

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;

    vecs[0] = '{8'h3C, 32'hDEAD_BEEF, 80'h3C_01_DEADBEEF_00000000, 8'h02};
    vecs[1] = '{8'h00, 32'h0000_0000, 80'h00_02_00000000_00000000, 8'h03};
    vecs[2] = '{8'hFF, 32'hFFFF_FFFF, 80'hFF_03_FFFFFFFF_00000000, 8'h04};
    vecs[3] = '{8'h5A, 32'h1234_5678, 80'h5A_04_12345678_00000000, 8'h05};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_loadOUT", {79'd0, loadOUT}, 80'd0);
    check("rst_newPKT", {79'd0, out_newPKT}, 80'd0);
    check("rst_donePKT", {79'd0, out_donePKT}, 80'd0);
    check("rst_out", out, 80'd0);
    check("rst_count", {72'd0, countOUT}, 80'd0);
    nR = 1'b1;
    @(negedge clk);

    // Single result: latency and layout
    drive(8'hA5, 32'h6565_6877, 80'hA5_00_65656877_00000000);
    @(negedge clk);
    check("lat1_newPKT", {79'd0, out_newPKT}, 80'd0);
    check("lat1_loadOUT", {79'd0, loadOUT}, 80'd1);
    newOUT = 1'b0;
    @(negedge clk);
    check("lat2_newPKT", {79'd0, out_newPKT}, 80'd1);
    check("single_pkt", out, add_pad(80'hA5_00_65656877_00000000));
    check("single_load_drop", {79'd0, loadOUT}, 80'd0);
    host_en = 1'b1;
    drain(50);
    check("single_count", {72'd0, countOUT}, 80'd1);

    // Vector table
    for (int v = 0; v < 4; v++) begin
      drive(vecs[v].info, vecs[v].data, vecs[v].exp_pkt);
      wait_load(40, ok);
      check("tbl_accept", {79'd0, ok}, 80'd1);
      release_result();
      drain(50);
      check("tbl_count", {72'd0, countOUT}, {72'd0, vecs[v].exp_cnt});
    end

    // Back-pressure: host silent, one result in the packet register and two in the FIFO
    host_en = 1'b0;
    send(8'h11, 32'h1111_0001, "bp_accept0");
    send(8'h22, 32'h2222_0002, "bp_accept1");
    send(8'h33, 32'h3333_0003, "bp_accept2");
    drive(8'h44, 32'h4444_0004, {8'h44, pred_cnt, 32'h4444_0004, 32'h0});
    wait_load(6, ok);
    check("bp_blocked", {79'd0, ok}, 80'd0);
    host_en = 1'b1;
    wait_load(40, ok);
    check("bp_late_accept", {79'd0, ok}, 80'd1);
    release_result();
    drain(100);
    check("bp_count", {72'd0, countOUT}, 80'd9);

    // Overlap: host acks 2 cycles after each offer
    host_delay = 2;
    for (int k = 0; k < 4; k++) send(8'hC0 + 8'(k), $urandom, "ovl_accept");
    drain(100);
    check("ovl_count", {72'd0, countOUT}, 80'd13);
    host_delay = 0;

    // Asynchronous reset while a packet is held in T_SEND
    host_en = 1'b0;
    send(8'h77, 32'hCAFE_F00D, "rst_mid_accept");
    for (int i = 0; i < 20 && !out_newPKT; i++) @(negedge clk);
    if (!out_newPKT) fail("rst_mid_offer");
    #20 nR = 1'b0;
    #1;
    check("rstmid_newPKT", {79'd0, out_newPKT}, 80'd0);
    check("rstmid_out", out, 80'd0);
    check("rstmid_loadOUT", {79'd0, loadOUT}, 80'd0);
    check("rstmid_count", {72'd0, countOUT}, 80'd0);
    check("rstmid_done", {79'd0, out_donePKT}, 80'd0);
    exp_q.delete();
    pred_cnt = 8'd0;
    @(negedge clk);
    @(negedge clk);
    nR = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_donePKT || out_newPKT) seen = 1'b1;
    end
    check("rst_no_done_after", {79'd0, seen}, 80'd0);

    // out_loadPKT while idle is ignored
    poke_load = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_donePKT || out_newPKT) seen = 1'b1;
    end
    poke_load = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (out_donePKT || out_newPKT) seen = 1'b1;
    end
    check("idle_load_ignored", {79'd0, seen}, 80'd0);
    check("idle_load_count", {72'd0, countOUT}, 80'd0);

    // Counter wrap: headers run 00..FF, then 00 again
    host_en = 1'b1;
    for (int k = 0; k < 256; k++) send(8'(k), $urandom, "wrap_accept");
    drain(200);
    check("wrap_count_zero", {72'd0, countOUT}, 80'd0);
    send(8'hEE, 32'h0BAD_F00D, "wrap_accept_last");
    drain(100);
    check("wrap_count_one", {72'd0, countOUT}, 80'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
